// File: rtl/keystream_pkg.sv
// Shared types and constants for the keystream generator.
// The KEYSTREAM_NONLINEAR_EN build option is handled in keystream_gen.sv.
package keystream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_READY  = 3'd2,
        ST_WARMUP = 3'd3,
        ST_RUN    = 3'd4
    } state_t;

    localparam logic [31:0] TAPS           = 32'h8020_0003;
    localparam logic [31:0] ZERO_KEY_SUBST = 32'hACE1_2468;
    localparam int          WARMUP_STEPS   = 32;
    localparam int          KEY_BYTES      = 4;

endpackage

// File: rtl/ks_lfsr_step.sv
// One step of the 32-bit Galois right-shift LFSR.
module ks_lfsr_step
    import keystream_pkg::*;
(
    input  logic [31:0] cur,
    output logic [31:0] nxt
);

    // Shift right, fold the taps back in when the bit shifted out was set.
    always_comb begin
        nxt = {1'b0, cur[31:1]} ^ (cur[0] ? TAPS : 32'h0000_0000);
    end

endmodule

// File: rtl/keystream_gen.sv
// Keystream generator: 4-byte key loader, 32-step LFSR warm-up, ready/valid byte output.
// Define KEYSTREAM_NONLINEAR_EN for the nonlinear output filter; default is lfsr[7:0].
module keystream_gen
    import keystream_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_byte,
    input  logic       key_wr,
    input  logic       start,
    output logic [7:0] ks_data,
    output logic       ks_valid,
    input  logic       ks_ready,
    output logic       busy,
    output logic       key_loaded
);

    localparam logic [5:0] WARMUP_LAST = 6'(WARMUP_STEPS - 1);
    localparam logic [2:0] LAST_BYTE   = 3'(KEY_BYTES - 1);

    state_t      state_r;
    state_t      state_nxt;
    logic [31:0] key_r;
    logic [2:0]  count_r;
    logic [31:0] lfsr_r;
    logic [31:0] lfsr_next_s;
    logic [5:0]  wcnt_r;
    logic        key_loaded_r;
    logic        new_key_s;
    logic        start_ok_s;
    logic [7:0]  ks_byte_s;

    ks_lfsr_step u_step (
        .cur (lfsr_r),
        .nxt (lfsr_next_s)
    );

`ifdef KEYSTREAM_NONLINEAR_EN
    assign ks_byte_s = lfsr_r[7:0] ^ (lfsr_r[15:8] & lfsr_r[23:16]);
`else
    assign ks_byte_s = lfsr_r[7:0];
`endif

    // A key write outside IDLE/LOAD restarts key entry; key_wr also outranks start.
    assign new_key_s  = key_wr && (state_r inside {ST_READY, ST_WARMUP, ST_RUN});
    assign start_ok_s = start && !key_wr && (state_r inside {ST_READY, ST_RUN});

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE:   state_nxt = key_wr ? ST_LOAD : ST_IDLE;
            ST_LOAD:   state_nxt = (key_wr && (count_r == LAST_BYTE)) ? ST_READY : ST_LOAD;
            ST_READY:  state_nxt = key_wr ? ST_LOAD : (start ? ST_WARMUP : ST_READY);
            ST_WARMUP: state_nxt = key_wr ? ST_LOAD :
                                   ((wcnt_r == WARMUP_LAST) ? ST_RUN : ST_WARMUP);
            ST_RUN:    state_nxt = key_wr ? ST_LOAD : (start ? ST_WARMUP : ST_RUN);
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Key shift register, byte counter, LFSR and warm-up counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_r        <= 32'h0000_0000;
            count_r      <= 3'd0;
            key_loaded_r <= 1'b0;
            lfsr_r       <= 32'h0000_0000;
            wcnt_r       <= 6'd0;
        end else begin
            if (key_wr) begin
                key_r <= {key_r[23:0], key_byte};
                if (new_key_s) begin
                    count_r      <= 3'd1;
                    key_loaded_r <= 1'b0;
                end else begin
                    count_r      <= count_r + 3'd1;
                    key_loaded_r <= (count_r == LAST_BYTE);
                end
            end else begin
                key_r        <= key_r;
                count_r      <= count_r;
                key_loaded_r <= key_loaded_r;
            end

            // An all-zero seed would lock the LFSR, so it is replaced.
            if (start_ok_s) begin
                lfsr_r <= (key_r == 32'h0000_0000) ? ZERO_KEY_SUBST : key_r;
                wcnt_r <= 6'd0;
            end else if (state_r == ST_WARMUP) begin
                lfsr_r <= lfsr_next_s;
                wcnt_r <= wcnt_r + 6'd1;
            end else if ((state_r == ST_RUN) && ks_ready) begin
                lfsr_r <= lfsr_next_s;
                wcnt_r <= wcnt_r;
            end else begin
                lfsr_r <= lfsr_r;
                wcnt_r <= wcnt_r;
            end
        end
    end

    // Outputs decoded from the state register; data is forced to zero when not valid.
    always_comb begin
        busy       = 1'b0;
        ks_valid   = 1'b0;
        ks_data    = 8'h00;
        key_loaded = key_loaded_r;
        case (state_r)
            ST_LOAD, ST_WARMUP: busy = 1'b1;
            ST_RUN: begin
                ks_valid = 1'b1;
                ks_data  = ks_byte_s;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_keystream_gen.sv
// Directed, table-driven self-checking bench for keystream_gen (both KEYSTREAM_NONLINEAR_EN builds).
module tb_keystream_gen;
    import keystream_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] key_byte;
    logic       key_wr;
    logic       start;
    logic [7:0] ks_data;
    logic       ks_valid;
    logic       ks_ready;
    logic       busy;
    logic       key_loaded;

    int n_checks = 0;
    int n_fail   = 0;

    keystream_gen dut (
        .clk        (clk),
        .rst        (rst),
        .key_byte   (key_byte),
        .key_wr     (key_wr),
        .start      (start),
        .ks_data    (ks_data),
        .ks_valid   (ks_valid),
        .ks_ready   (ks_ready),
        .busy       (busy),
        .key_loaded (key_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] key;
        logic [31:0] seed;
    } vec_t;

    function automatic logic [31:0] m_step(input logic [31:0] s);
        logic lsb;
        lsb = s[0];
        s   = s >> 1;
        if (lsb) s = s ^ 32'h8020_0003;
        return s;
    endfunction

    function automatic logic [7:0] m_out(input logic [31:0] s);
`ifdef KEYSTREAM_NONLINEAR_EN
        return s[7:0] ^ (s[15:8] & s[23:16]);
`else
        return s[7:0];
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        key_byte = b;
        key_wr   = 1'b1;
        tick();
        key_wr   = 1'b0;
    endtask

    task automatic load_key(input logic [31:0] k);
        for (int i = 0; i < 4; i++) write_byte(k[31-8*i -: 8]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Load, start, check warm-up latency, backpressure and 16 accepted bytes.
    task automatic run_vector(input vec_t v);
        logic [31:0] m;
        load_key(v.key);
        check("key_loaded_after_load", 32'(key_loaded), 32'd1);
        check("busy_ready", 32'(busy), 32'd0);
        pulse_start();
        check("busy_warmup", 32'(busy), 32'd1);
        check("valid_after_E0", 32'(ks_valid), 32'd0);
        for (int c = 1; c < 32; c++) begin
            tick();
            check("valid_low_warmup", 32'(ks_valid), 32'd0);
        end
        tick();
        m = v.seed;
        for (int s = 0; s < 32; s++) m = m_step(m);
        check("valid_after_E32", 32'(ks_valid), 32'd1);
        check("busy_run", 32'(busy), 32'd0);
        check("first_byte", 32'(ks_data), 32'(m_out(m)));
        ks_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("hold_data", 32'(ks_data), 32'(m_out(m)));
            check("hold_valid", 32'(ks_valid), 32'd1);
        end
        for (int b = 0; b < 16; b++) begin
            ks_ready = 1'b1;
            check("stream_byte", 32'(ks_data), 32'(m_out(m)));
            tick();
            m = m_step(m);
        end
        ks_ready = 1'b0;
        check("byte_after_stream", 32'(ks_data), 32'(m_out(m)));
    endtask

    vec_t tab[5];

    initial begin
        tab[0] = '{key: 32'h0000_0001, seed: 32'h0000_0001};
        tab[1] = '{key: 32'h0000_0000, seed: 32'hACE1_2468};
        tab[2] = '{key: 32'hACE1_2468, seed: 32'hACE1_2468};
        tab[3] = '{key: 32'hDEAD_BEEF, seed: 32'hDEAD_BEEF};
        tab[4] = '{key: 32'h8000_0000, seed: 32'h8000_0000};

        rst = 1'b1; key_byte = 8'h00; key_wr = 1'b0; start = 1'b0; ks_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(ks_valid), 32'd0);
        check("rst_data", 32'(ks_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_loaded", 32'(key_loaded), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_after_rst", 32'(dut.state_r), 32'(ST_IDLE));

        // Start in IDLE is ignored.
        pulse_start();
        check("start_in_idle", 32'(dut.state_r), 32'(ST_IDLE));

        for (int i = 0; i < 5; i++) run_vector(tab[i]);

        // Reset asserted mid-RUN clears outputs without waiting for a clock edge.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrun_rst_valid", 32'(ks_valid), 32'd0);
        check("midrun_rst_data", 32'(ks_data), 32'd0);
        check("midrun_rst_busy", 32'(busy), 32'd0);
        check("midrun_rst_loaded", 32'(key_loaded), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_state", 32'(dut.state_r), 32'(ST_IDLE));
        check("post_rst_key", dut.key_r, 32'd0);
        check("post_rst_count", 32'(dut.count_r), 32'd0);

        // Partial load: start in LOAD is ignored.
        write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
        pulse_start();
        for (int c = 0; c < 40; c++) begin
            tick();
            check("partial_valid", 32'(ks_valid), 32'd0);
        end
        check("partial_loaded", 32'(key_loaded), 32'd0);
        check("partial_busy", 32'(busy), 32'd1);
        check("partial_count", 32'(dut.count_r), 32'd3);
        write_byte(8'h44);
        check("partial_done_state", 32'(dut.state_r), 32'(ST_READY));
        check("partial_key", dut.key_r, 32'h1122_3344);

        // key_wr and start together in READY: key_wr wins.
        key_byte = 8'h55; key_wr = 1'b1; start = 1'b1;
        tick();
        key_wr = 1'b0; start = 1'b0;
        check("prio_state", 32'(dut.state_r), 32'(ST_LOAD));
        check("prio_count", 32'(dut.count_r), 32'd1);
        check("prio_loaded", 32'(key_loaded), 32'd0);
        write_byte(8'h66); write_byte(8'h77); write_byte(8'h88);

        // Abort warm-up with a key write at warm-up cycle 10.
        pulse_start();
        repeat (10) tick();
        check("abort_in_warmup", 32'(dut.state_r), 32'(ST_WARMUP));
        write_byte(8'h99);
        check("abort_state", 32'(dut.state_r), 32'(ST_LOAD));
        check("abort_count", 32'(dut.count_r), 32'd1);
        check("abort_loaded", 32'(key_loaded), 32'd0);
        for (int c = 0; c < 40; c++) begin
            tick();
            check("abort_valid", 32'(ks_valid), 32'd0);
        end

        // Key write in RUN drops valid on the next cycle.
        write_byte(8'h01); write_byte(8'h02); write_byte(8'h03);
        pulse_start();
        repeat (32) tick();
        check("run_valid", 32'(ks_valid), 32'd1);
        write_byte(8'hAA);
        check("rekey_valid", 32'(ks_valid), 32'd0);
        check("rekey_data", 32'(ks_data), 32'd0);
        check("rekey_loaded", 32'(key_loaded), 32'd0);
        check("rekey_count", 32'(dut.count_r), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
